// File: rtl/dense_stream_mac.sv
// Time-multiplexed dense layer: OUT_CH parallel MACs over one input element per handshake.
// Define DENSE_RELU_EN to clamp negative biased sums to zero before output saturation.
module dense_stream_mac #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int IN_LEN     = 9216,
  parameter int OUT_CH     = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic [DATA_WIDTH*OUT_CH-1:0] in_weight,
  input  logic                         in_last,
  input  logic [DATA_WIDTH*OUT_CH-1:0] bias_i,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH*OUT_CH-1:0] result_o,
  output logic                         len_err_o
);

  localparam int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(IN_LEN);
  localparam int CNT_WIDTH  = $clog2(IN_LEN+1);
  localparam int PROD_WIDTH = 2*DATA_WIDTH;
  localparam int SUM_WIDTH  = ACC_WIDTH + 1;

  localparam logic signed [SUM_WIDTH-1:0] SAT_MAX =
    SUM_WIDTH'((64'sd1 <<< (DATA_WIDTH-1)) - 64'sd1);
  localparam logic signed [SUM_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, ACCUM, BIAS, OUT} state_t;

  state_t                        state;
  logic                          prod_valid;
  logic [CNT_WIDTH-1:0]          count;
  logic signed [PROD_WIDTH-1:0]  prod      [OUT_CH];
  logic signed [PROD_WIDTH-1:0]  prod_next [OUT_CH];
  logic signed [ACC_WIDTH-1:0]   acc       [OUT_CH];
  logic signed [SUM_WIDTH-1:0]   sum       [OUT_CH];
  logic [DATA_WIDTH*OUT_CH-1:0]  result_next;

  logic                 accept;
  logic [CNT_WIDTH-1:0] count_next;
  logic                 count_full;
  logic                 vec_end;
  logic                 len_mismatch;

  assign accept       = in_valid & in_ready;
  assign count_next   = count + CNT_WIDTH'(1);
  assign count_full   = (count_next == CNT_WIDTH'(IN_LEN));
  assign vec_end      = in_last | count_full;
  assign len_mismatch = in_last ^ count_full;

  // Scaled products for the current element, and the biased/clamped result of the accumulators.
  always_comb begin
    result_next = '0;
    for (int c = 0; c < OUT_CH; c++) begin
      prod_next[c] = (PROD_WIDTH'($signed(in_data)) *
                      PROD_WIDTH'($signed(in_weight[c*DATA_WIDTH +: DATA_WIDTH]))) >>> FRAC_BITS;
      sum[c] = SUM_WIDTH'(acc[c]) + SUM_WIDTH'($signed(bias_i[c*DATA_WIDTH +: DATA_WIDTH]));
`ifdef DENSE_RELU_EN
      if (sum[c][SUM_WIDTH-1]) sum[c] = '0;
`endif
      if (sum[c] > SAT_MAX)
        result_next[c*DATA_WIDTH +: DATA_WIDTH] = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      else if (sum[c] < SAT_MIN)
        result_next[c*DATA_WIDTH +: DATA_WIDTH] = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      else
        result_next[c*DATA_WIDTH +: DATA_WIDTH] = sum[c][DATA_WIDTH-1:0];
    end
  end

  // Products are registered one stage ahead of the adders, so BIAS waits one cycle for the
  // final product to land in the accumulators before forming the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      result_o   <= '0;
      len_err_o  <= 1'b0;
      count      <= '0;
      prod_valid <= 1'b0;
      for (int c = 0; c < OUT_CH; c++) begin
        prod[c] <= '0;
        acc[c]  <= '0;
      end
    end else begin
      len_err_o  <= 1'b0;
      prod_valid <= accept;
      if (accept) begin
        count <= count_next;
        for (int c = 0; c < OUT_CH; c++) prod[c] <= prod_next[c];
      end
      if (prod_valid) begin
        for (int c = 0; c < OUT_CH; c++) acc[c] <= acc[c] + ACC_WIDTH'(prod[c]);
      end

      case (state)
        IDLE, ACCUM: begin
          if (accept && vec_end) begin
            state     <= BIAS;
            in_ready  <= 1'b0;
            len_err_o <= len_mismatch;
          end else begin
            in_ready <= 1'b1;
            if (accept) state <= ACCUM;
          end
        end
        BIAS: begin
          if (!prod_valid) begin
            result_o  <= result_next;
            out_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            count     <= '0;
            state     <= IDLE;
            for (int c = 0; c < OUT_CH; c++) acc[c] <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_stream_mac.sv
// Randomized bench for dense_stream_mac (IN_LEN=3, OUT_CH=2) against an arithmetic reference model.
// Honours DENSE_RELU_EN the same way as the design build.
module tb_dense_stream_mac;

  localparam int DW     = 16;
  localparam int FB     = 8;
  localparam int IN_LEN = 3;
  localparam int OUT_CH = 2;

`ifdef DENSE_RELU_EN
  localparam logic [31:0] T1_EXP  = 32'h0000_0140;
  localparam logic [31:0] T2B_EXP = 32'h0000_0000;
`else
  localparam logic [31:0] T1_EXP  = 32'hFD00_0140;
  localparam logic [31:0] T2B_EXP = 32'h8000_8000;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_data = '0;
  logic [31:0] in_weight = '0;
  logic [31:0] bias_i = '0;
  logic        in_ready;
  logic        out_valid;
  logic        len_err_o;
  logic [31:0] result_o;

  int asserts = 0;
  int failures = 0;
  int cyc = 0;
  int err_total = 0;

  logic [15:0] vx [3];
  logic [15:0] vw [2][3];
  logic [15:0] vb [2];

  dense_stream_mac #(
    .DATA_WIDTH(DW), .FRAC_BITS(FB), .IN_LEN(IN_LEN), .OUT_CH(OUT_CH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_weight(in_weight), .in_last(in_last), .bias_i(bias_i),
    .out_valid(out_valid), .out_ready(out_ready), .result_o(result_o),
    .len_err_o(len_err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (len_err_o) err_total <= err_total + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    asserts++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Each channel: sum over elements of floor(x*w / 2^FB), plus bias, optional ReLU, clamp to 16 bits.
  function automatic logic [31:0] modelResult(input int n);
    logic [31:0] r;
    longint s;
    r = '0;
    for (int c = 0; c < 2; c++) begin
      s = 0;
      for (int i = 0; i < n; i++)
        s += (longint'($signed(vx[i])) * longint'($signed(vw[c][i]))) >>> FB;
      s += longint'($signed(vb[c]));
`ifdef DENSE_RELU_EN
      if (s < 0) s = 0;
`endif
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
      r[c*16 +: 16] = 16'(s);
    end
    return r;
  endfunction

  task automatic loadTest1();
    vx[0] = 16'h0100; vx[1] = 16'h0200; vx[2] = 16'hFF00;
    for (int i = 0; i < 3; i++) vw[0][i] = 16'h0080;
    vw[1][0] = 16'h0100; vw[1][1] = 16'hFF00; vw[1][2] = 16'h0200;
    vb[0] = 16'h0040; vb[1] = 16'h0000;
  endtask

  task automatic loadSat(input logic [15:0] x);
    for (int i = 0; i < 3; i++) begin
      vx[i] = x; vw[0][i] = 16'h7F00; vw[1][i] = 16'h7F00;
    end
    vb[0] = '0; vb[1] = '0;
  endtask

  task automatic applyStimulus(input string tag, input int n, input bit gap, input int hold);
    logic [31:0] exp;
    int last_edge;
    int start_err;
    int waitc;
    exp = modelResult(n);
    start_err = err_total;
    last_edge = 0;
    bias_i = {vb[1], vb[0]};
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data = vx[i];
      in_weight = {vw[1][i], vw[0][i]};
      in_last = (i == n-1);
      waitc = 0;
      while (!in_ready && waitc < 20) begin
        @(negedge clk);
        waitc++;
      end
      if (!in_ready) begin
        checkOutput({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      last_edge = cyc;
      in_valid = 1'b0;
      in_last = 1'b0;
      if (gap && i < n-1) @(negedge clk);
    end
    waitc = 0;
    while (!out_valid && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    if (!out_valid) return;
    checkOutput({tag, "_latency"}, 32'(cyc - last_edge), 32'd2);
    checkOutput({tag, "_result"}, result_o, exp);
    checkOutput({tag, "_len_err"}, 32'(err_total - start_err), (n != IN_LEN) ? 32'd1 : 32'd0);
    checkOutput({tag, "_ready_busy"}, 32'(in_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      in_valid = (h % 2 == 0);
      in_data = 16'($urandom);
      in_weight = $urandom;
      in_last = 1'($urandom);
      @(negedge clk);
      checkOutput({tag, "_hold_result"}, result_o, exp);
      checkOutput({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      checkOutput({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_done_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_done_ready"}, 32'(in_ready), 32'd1);
    checkOutput({tag, "_kept_result"}, result_o, exp);
  endtask

  initial begin
    int waitc;
    $display("[TB] starting dense_stream_mac bench");
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_result", result_o, 32'd0);
    checkOutput("rst_len_err", 32'(len_err_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    loadTest1();
    applyStimulus("t1", 3, 1'b0, 0);
    checkOutput("t1_const", result_o, T1_EXP);

    loadSat(16'h7F00);
    applyStimulus("t2a", 3, 1'b0, 0);
    checkOutput("t2a_const", result_o, 32'h7FFF_7FFF);
    loadSat(16'h8100);
    applyStimulus("t2b", 3, 1'b0, 0);
    checkOutput("t2b_const", result_o, T2B_EXP);

    loadTest1();
    applyStimulus("t3", 3, 1'b0, 5);
    loadSat(16'h7F00);
    applyStimulus("t3_next", 3, 1'b0, 0);

    loadTest1();
    applyStimulus("t4", 2, 1'b0, 1);
    loadTest1();
    applyStimulus("t4_next", 3, 1'b0, 0);
    checkOutput("t4_next_const", result_o, T1_EXP);

    loadSat(16'h7F00);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data = vx[i];
      in_weight = {vw[1][i], vw[0][i]};
      in_last = 1'b0;
      waitc = 0;
      while (!in_ready && waitc < 20) begin
        @(negedge clk);
        waitc++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("t5_rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("t5_rst_result", result_o, 32'd0);
    checkOutput("t5_rst_len_err", 32'(len_err_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    loadTest1();
    applyStimulus("t5", 3, 1'b0, 0);
    checkOutput("t5_const", result_o, T1_EXP);

    loadTest1();
    applyStimulus("t6", 3, 1'b1, 0);

    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < 3; i++) begin
        vx[i] = 16'($urandom);
        vw[0][i] = 16'($urandom);
        vw[1][i] = 16'($urandom);
      end
      vb[0] = 16'($urandom);
      vb[1] = 16'($urandom);
      applyStimulus("rand", int'($urandom_range(1, 3)), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
